instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder_pkg.sv | 52 +++++
 rtl/instruction_encoder_if.sv | 32 +++
 rtl/instruction_encoder_imm_field_packer.sv | 96 +++++++++
 rtl/instruction_encoder.sv | 102 ++++++++++
 tb/tb_instruction_encoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode, format and error definitions
// for the RV32I instruction encoder.
package instruction_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_OPC   = 2'b11
  } err_e;

  typedef struct packed {
    logic [31:0] instr;
    err_e        err;
  } enc_t;

  // True when v[31:msb] is a pure sign extension.
  function automatic logic sext_ok(
    input logic [31:0] v,
    input int          msb
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= msb && v[i] != v[msb])
        ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request / result bundle of the encoder;
// slave is the encoder side, master the requester side.
interface instruction_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  instruction_encoder_pkg::err_e err;

  modport slave (
    input  in_valid, opcode, funct3, funct7,
    input  rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, err
  );

  modport master (
    output in_valid, opcode, funct3, funct7,
    output rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, err
  );

endinterface

// File: rtl/instruction_encoder_imm_field_packer.sv
// Combinational field scatter and immediate
// range / alignment check for one request.
module imm_field_packer
  import instruction_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output err_e        err_o
);

  fmt_e fmt;
  logic shamt;
  logic rng_bad;
  logic aln_bad;

  always_comb begin
    fmt = FMT_X;
    unique case (opcode_i)
      OPC_OP:     fmt = FMT_R;
      OPC_JALR,
      OPC_LOAD,
      OPC_OP_IMM,
      OPC_FENCE,
      OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:  fmt = FMT_S;
      OPC_BRANCH: fmt = FMT_B;
      OPC_LUI,
      OPC_AUIPC:  fmt = FMT_U;
      OPC_JAL:    fmt = FMT_J;
      default:    fmt = FMT_X;
    endcase
  end

  assign shamt = (opcode_i == OPC_OP_IMM) &&
                 (funct3_i == 3'b001 ||
                  funct3_i == 3'b101);

  always_comb begin
    word_o  = '0;
    rng_bad = 1'b0;
    aln_bad = 1'b0;
    unique case (fmt)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i,
                       funct3_i, rd_i, opcode_i};
      FMT_I: begin
        if (shamt) begin
          word_o  = {funct7_i, imm_i[4:0], rs1_i,
                     funct3_i, rd_i, opcode_i};
          rng_bad = |imm_i[31:5];
        end else begin
          word_o  = {imm_i[11:0], rs1_i,
                     funct3_i, rd_i, opcode_i};
          rng_bad = !sext_ok(imm_i, 11);
        end
      end
      FMT_S: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i,
                   funct3_i, imm_i[4:0], opcode_i};
        rng_bad = !sext_ok(imm_i, 11);
      end
      FMT_B: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i,
                   rs1_i, funct3_i, imm_i[4:1],
                   imm_i[11], opcode_i};
        rng_bad = !sext_ok(imm_i, 12);
        aln_bad = imm_i[0];
      end
      FMT_U: begin
        word_o  = {imm_i[31:12], rd_i, opcode_i};
        aln_bad = |imm_i[11:0];
      end
      FMT_J: begin
        word_o  = {imm_i[20], imm_i[10:1],
                   imm_i[11], imm_i[19:12],
                   rd_i, opcode_i};
        rng_bad = !sext_ok(imm_i, 20);
        aln_bad = imm_i[0];
      end
      default: word_o = '0;
    endcase
  end

  always_comb begin
    if (fmt == FMT_X)  err_o = ERR_OPC;
    else if (rng_bad)  err_o = ERR_RANGE;
    else if (aln_bad)  err_o = ERR_ALIGN;
    else               err_o = ERR_OK;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready RV32I encoder with
// NOP substitution and a saturating error count.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instruction_encoder_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0] pk_word;
  err_e        pk_err;
  enc_t        pk;

  logic s1_v_q, s1_v_d;
  enc_t s1_q,   s1_d;
  logic s2_v_q, s2_v_d;
  enc_t s2_q,   s2_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic s2_load;
  logic s1_adv;
  logic accept;
  logic xfer;

  imm_field_packer u_pack (
    .opcode_i (bus.opcode),
    .funct3_i (bus.funct3),
    .funct7_i (bus.funct7),
    .rd_i     (bus.rd),
    .rs1_i    (bus.rs1),
    .rs2_i    (bus.rs2),
    .imm_i    (bus.imm),
    .word_o   (pk_word),
    .err_o    (pk_err)
  );

  assign pk.err   = pk_err;
  assign pk.instr = (pk_err != ERR_OK) ?
                    NOP_WORD : pk_word;

  assign s2_load = !s2_v_q || bus.out_ready;
  assign s1_adv  = s1_v_q && s2_load;
  assign accept  = bus.in_valid && bus.in_ready;
  assign xfer    = s2_v_q && bus.out_ready;

  assign bus.in_ready  = !s1_v_q || s2_load;
  assign bus.out_valid = s2_v_q;
  assign bus.instr     = s2_q.instr;
  assign bus.err       = s2_q.err;
  assign err_count     = cnt_q;

  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    if (accept) begin
      s1_v_d = 1'b1;
      s1_d   = pk;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
  end

  // S2 refills from S1 in the same cycle it drains.
  always_comb begin
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q)
        s2_d = s1_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && s2_q.err != ERR_OK &&
        cnt_q != '1)
      cnt_d = cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      s2_q   <= '0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
      s2_v_q <= s2_v_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder.
// Second instance mirrors the stimulus with a 2-bit counter.
module tb_instruction_encoder;

  logic clk;
  logic reset_n;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int errors;
  int checks;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_OPI  = 7'b0010011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  instruction_encoder_if bus ();
  instruction_encoder_if bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.opcode    = bus.opcode;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7    = bus.funct7;
  assign bus2.rd        = bus.rd;
  assign bus2.rs1       = bus.rs1;
  assign bus2.rs2       = bus.rs2;
  assign bus2.imm       = bus.imm;
  assign bus2.out_ready = bus.out_ready;

  instruction_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  instruction_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus2.slave),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic single(
    input string       tag,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm,
    input logic [31:0] ei,
    input logic [1:0]  ee
  );
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(op, f3, f7, rd, rs1, rs2, imm);
    chk({tag, ":rdy"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, ":lat1"}, 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk({tag, ":vld"}, 32'(bus.out_valid), 1);
    chk({tag, ":instr"}, bus.instr, ei);
    chk({tag, ":err"}, 32'(bus.err), 32'(ee));
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b1;
    bus.out_ready = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ovalid", 32'(bus.out_valid), 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cnt", 32'(err_count), 0);
    chk("rst_irdy", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    single("beq", OP_BR, 3'd0, 7'd0, 5'd0, 5'd1,
           5'd2, -32'sd8, 32'hFE208CE3, 2'b00);
    single("jal", OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0,
           5'd0, 32'd2048, 32'h001000EF, 2'b00);
    single("lui", OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0,
           5'd0, 32'h12345000, 32'h123452B7, 2'b00);
    single("sw", OP_ST, 3'd2, 7'd0, 5'd0, 5'd2,
           5'd3, -32'sd4, 32'hFE312E23, 2'b00);
    single("addi", OP_OPI, 3'd0, 7'd0, 5'd1, 5'd0,
           5'd0, -32'sd1, 32'hFFF00093, 2'b00);
    single("srai", OP_OPI, 3'd5, 7'h20, 5'd1, 5'd2,
           5'd0, 32'd3, 32'h40315093, 2'b00);
    single("add", OP_R, 3'd0, 7'd0, 5'd3, 5'd1,
           5'd2, 32'd0, 32'h002081B3, 2'b00);
    single("lw", OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd2,
           5'd0, 32'd2047, 32'h7FF12083, 2'b00);
    single("addi_rng", OP_OPI, 3'd0, 7'd0, 5'd1,
           5'd0, 5'd0, 32'd2048, 32'h00000013, 2'b01);
    chk("cnt_one", 32'(err_count), 1);
    single("lui_aln", OP_LUI, 3'd0, 7'd0, 5'd5,
           5'd0, 5'd0, 32'h12345001, 32'h00000013,
           2'b10);
    single("bad_opc", OP_BAD, 3'd0, 7'd0, 5'd1,
           5'd0, 5'd0, 32'd0, 32'h00000013, 2'b11);
    single("b_max", OP_BR, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, 32'd4094, 32'h7E000FE3, 2'b00);
    single("b_over", OP_BR, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, 32'd4096, 32'h00000013, 2'b01);
    single("b_min", OP_BR, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, -32'sd4096, 32'h80000063, 2'b00);
    single("b_odd", OP_BR, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, 32'd3, 32'h00000013, 2'b10);
    single("b_prio", OP_BR, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, 32'd5001, 32'h00000013, 2'b01);
    single("sh_rng", OP_OPI, 3'd1, 7'd0, 5'd1, 5'd1,
           5'd0, 32'd32, 32'h00000013, 2'b01);
    single("j_min", OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0,
           5'd0, -32'sd1048576, 32'h8000006F, 2'b00);
    chk("cnt_seven", 32'(err_count), 7);
    chk("cnt2_sat_a", 32'(err_count2), 3);

    // Backpressure: three back-to-back, sink stalled.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(OP_OPI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    chk("bp_rdyA", 32'(bus.in_ready), 1);
    @(negedge clk);
    drive(OP_OPI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
    chk("bp_rdyB", 32'(bus.in_ready), 1);
    @(negedge clk);
    drive(OP_OPI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    chk("bp_full", 32'(bus.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_rdy", 32'(bus.in_ready), 0);
      chk("bp_hold_v", 32'(bus.out_valid), 1);
      chk("bp_hold_i", bus.instr, 32'h00100093);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_B_v", 32'(bus.out_valid), 1);
    chk("bp_B_i", bus.instr, 32'h00200093);
    @(posedge clk); #1;
    chk("bp_C_v", 32'(bus.out_valid), 1);
    chk("bp_C_i", bus.instr, 32'h00300093);
    @(posedge clk); #1;
    chk("bp_empty", 32'(bus.out_valid), 0);
    chk("bp_cnt", 32'(err_count), 7);

    // Asynchronous reset with both stages full.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(OP_BAD, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    drive(OP_LUI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_full", 32'(bus.in_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_ovalid", 32'(bus.out_valid), 0);
    chk("mid_cnt", 32'(err_count), 0);
    chk("mid_cnt2", 32'(err_count2), 0);
    chk("mid_instr", bus.instr, 0);
    chk("mid_irdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rel_nostale", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("rel_first_v", 32'(bus.out_valid), 1);
    chk("rel_first_i", bus.instr, 32'h001000EF);
    @(posedge clk); #1;
    chk("rel_drain", 32'(bus.out_valid), 0);

    // Five errored transfers; the 2-bit counter saturates.
    for (int i = 0; i < 5; i++)
      single("sat", OP_BAD, 3'd0, 7'd0, 5'd0, 5'd0,
             5'd0, 32'd0, 32'h00000013, 2'b11);
    chk("sat_cnt8", 32'(err_count), 5);
    chk("sat_cnt2", 32'(err_count2), 3);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
